// File: rtl/dma_ctrl_pkg.sv
// dma_ctrl_pkg: shared types and constants for the DMA stream-source controller.
//   state_e   : controller FSM states (IDLE/RUN/DONE), encoded as on gpio1/led.
//   DATA_W    : AXI4-Stream data width.
//   TKEEP_ALL : tkeep value driven on every master beat.
package dma_ctrl_pkg;

   localparam int         DATA_W    = 32;
   localparam logic [3:0] TKEEP_ALL = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through output.
//   clk_i, rst_i          : clock, synchronous active-high reset (empties FIFO)
//   wr_en_i, wr_data_i    : push; ignored while full
//   rd_en_i, rd_data_o    : pop; rd_data_o always shows the head entry
//   full_o, empty_o       : occupancy flags
//   level_o               : number of stored entries (0..DEPTH)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16,
   localparam int AW  = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q;
   logic             wr_fire, rd_fire;

   assign full_o    = (level_q == (AW+1)'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign level_o   = level_q;
   assign wr_fire   = wr_en_i && !full_o;
   assign rd_fire   = rd_en_i && !empty_o;
   // Head is read straight from storage: a word written at an edge is
   // visible on rd_data_o right after that edge.
   assign rd_data_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_fire, rd_fire})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/dma_ctrl.sv
// dma_ctrl: emits one AXI4-Stream packet per software start, either a
// generated indexed pattern or words looped back through a FIFO.
//   clock, reset          : sole clock; synchronous active-high reset
//   gpio0                 : [0] start (level), [1] mode (0 gen, 1 loopback)
//   gpio1                 : {pkt_cnt, fifo_level[7:0], 6'b0, state}
//   led                   : {pkt_cnt[7:0], fifo_full, fifo_empty, state}
//   s_t*                  : AXIS slave into the loopback FIFO (tkeep ignored)
//   m_t*                  : AXIS master output
module dma_ctrl
   import dma_ctrl_pkg::*;
#(
   parameter int PKT_LEN    = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clock,
   input  logic              reset,
   output logic [11:0]       led,
   input  logic [31:0]       gpio0,
   output logic [31:0]       gpio1,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic [3:0]        s_tkeep,
   input  logic              s_tlast,
   input  logic              s_tvalid,
   output logic              s_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic [3:0]        m_tkeep,
   output logic              m_tlast,
   output logic              m_tvalid,
   input  logic              m_tready
);

   localparam int          LVL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] K_LAST = 16'(PKT_LEN - 1);

   state_e      state_q, state_d;
   logic        mode_q;                 // 1 = loopback, latched at start
   logic [15:0] k_q, seq_q, pkt_cnt_q;

   logic              fifo_wr, fifo_rd, fifo_full, fifo_empty;
   logic [DATA_W:0]   fifo_dout;
   logic [LVL_W-1:0]  fifo_level;
   logic              xfer, last_xfer, gen_xfer;

   // tkeep and the spare control bits are deliberately unused.
   logic unused_ok;
   assign unused_ok = ^{s_tkeep, gpio0[31:2]};

   assign s_tready = !fifo_full && !reset;
   assign fifo_wr  = s_tvalid && s_tready;

   sync_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clock),
      .rst_i     (reset),
      .wr_en_i   (fifo_wr),
      .wr_data_i ({s_tlast, s_tdata}),
      .rd_en_i   (fifo_rd),
      .rd_data_o (fifo_dout),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (fifo_level)
   );

   always_comb begin
      state_d  = state_q;
      m_tvalid = 1'b0;
      m_tdata  = '0;
      m_tlast  = 1'b0;
      if (state_q == RUN) begin
         if (mode_q) begin
            m_tvalid = !fifo_empty;
            if (!fifo_empty) begin
               m_tdata = fifo_dout[DATA_W-1:0];
               m_tlast = fifo_dout[DATA_W];
            end
         end else begin
            m_tvalid = 1'b1;
            m_tdata  = {k_q, seq_q};
            m_tlast  = (k_q == K_LAST);
         end
      end
      case (state_q)
         IDLE:    if (gpio0[0]) state_d = RUN;
         RUN:     if (m_tvalid && m_tready && m_tlast) state_d = DONE;
         DONE:    if (!gpio0[0]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign m_tkeep   = TKEEP_ALL;
   assign xfer      = m_tvalid && m_tready;
   assign last_xfer = xfer && m_tlast;
   assign gen_xfer  = xfer && !mode_q;
   assign fifo_rd   = xfer && mode_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         mode_q    <= 1'b0;
         k_q       <= '0;
         seq_q     <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && gpio0[0]) mode_q <= gpio0[1];
         if (gen_xfer) begin
            k_q   <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
            seq_q <= seq_q + 1'b1;
         end
         if (last_xfer) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      end
   end

   assign gpio1 = {pkt_cnt_q, 8'(fifo_level), 6'b0, state_q};
   assign led   = {pkt_cnt_q[7:0], fifo_full, fifo_empty, state_q};

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: expected master beats are queued when
// stimulus is driven and compared as the DUT presents them.
module tb_dma_ctrl;

   localparam int PKT = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] led;
   logic [31:0] gpio0, gpio1;
   logic [31:0] s_tdata, m_tdata;
   logic [3:0]  s_tkeep, m_tkeep;
   logic        s_tlast, s_tvalid, s_tready;
   logic        m_tlast, m_tvalid, m_tready;

   int          total = 0;
   int          bad   = 0;
   logic [32:0] exp_q [$];
   logic [15:0] tb_seq;

   dma_ctrl #(.PKT_LEN(PKT), .FIFO_DEPTH(16)) dut (
      .clock    (clock),
      .reset    (reset),
      .led      (led),
      .gpio0    (gpio0),
      .gpio1    (gpio1),
      .s_tdata  (s_tdata),
      .s_tkeep  (s_tkeep),
      .s_tlast  (s_tlast),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tkeep  (m_tkeep),
      .m_tlast  (m_tlast),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Queue n generated words starting at index 0, advancing the seq model.
   task automatic push_gen(input int n);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({(k == PKT - 1), 16'(k), tb_seq});
         tb_seq = tb_seq + 16'd1;
      end
   endtask

   task automatic wait_done(input bit bp);
      bit done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (bp) m_tready = ~m_tready;
         tick();
         if (gpio1[1:0] == 2'd2) done = 1'b1;
      end
      if (!done) check("done_timeout", 64'(gpio1[1:0]), 64'(2));
      m_tready = 1'b1;
   endtask

   // Every presented beat must equal the queue head (also while stalled,
   // which covers hold-stable); pop only on handshake.
   always @(negedge clock) begin
      if (m_tvalid === 1'b1) begin
         if (exp_q.size() == 0) check("q_underrun", 64'(exp_q.size()), 64'(1));
         else begin
            check("beat", 64'({m_tlast, m_tdata}), 64'(exp_q[0]));
            if (m_tready === 1'b1) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      reset = 1'b1; gpio0 = '0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
      s_tvalid = 1'b0; m_tready = 1'b0; tb_seq = '0;
      repeat (2) tick();
      check("rst_gpio1", 64'(gpio1), 64'(0));
      check("rst_led", 64'(led), 64'(12'h004));
      check("rst_mvalid", 64'(m_tvalid), 64'(0));
      check("rst_mdata", 64'({m_tlast, m_tdata}), 64'(0));
      check("rst_sready", 64'(s_tready), 64'(0));
      check("rst_tkeep", 64'(m_tkeep), 64'(4'hF));
      reset = 1'b0;
      m_tready = 1'b1;               // ready before start must not matter
      tick();
      check("idle_sready", 64'(s_tready), 64'(1));
      check("idle_mvalid", 64'(m_tvalid), 64'(0));

      // packet 1: generator
      push_gen(PKT);
      gpio0 = 32'd1;
      tick();
      check("start_state", 64'(gpio1[1:0]), 64'(1));
      wait_done(1'b0);
      check("p1_q_empty", 64'(exp_q.size()), 64'(0));
      check("p1_cnt", 64'(gpio1[31:16]), 64'(1));
      check("p1_mvalid", 64'(m_tvalid), 64'(0));
      tick();
      check("hold_done", 64'(gpio1[1:0]), 64'(2));

      // packet 2: one low cycle of start then restart
      gpio0 = 32'd0;
      tick();
      check("back_idle", 64'(gpio1[1:0]), 64'(0));
      push_gen(PKT);
      gpio0 = 32'd1;
      wait_done(1'b0);
      check("p2_q_empty", 64'(exp_q.size()), 64'(0));
      check("p2_cnt", 64'(gpio1[31:16]), 64'(2));
      check("p2_led", 64'(led[11:4]), 64'(2));

      // packet 3: backpressure toggling every cycle
      gpio0 = 32'd0;
      tick();
      push_gen(PKT);
      gpio0 = 32'd1;
      wait_done(1'b1);
      check("p3_q_empty", 64'(exp_q.size()), 64'(0));
      check("p3_cnt", 64'(gpio1[31:16]), 64'(3));

      // loopback: 5 words, tlast on the last
      gpio0 = 32'd0;
      tick();
      gpio0 = 32'd3;
      for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), 32'hA0 + 32'(i)});
      for (int i = 0; i < 5; i++) begin
         s_tvalid = 1'b1; s_tdata = 32'hA0 + 32'(i); s_tlast = (i == 4); s_tkeep = 4'h3;
         tick();
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      wait_done(1'b0);
      check("lb_q_empty", 64'(exp_q.size()), 64'(0));
      check("lb_state", 64'(gpio1[1:0]), 64'(2));
      check("lb_cnt", 64'(gpio1[31:16]), 64'(4));
      check("lb_fifo_empty", 64'(led[2]), 64'(1));

      // FIFO full: 17 pushes with nothing draining
      gpio0 = 32'd0;
      m_tready = 1'b0;
      tick();
      for (int i = 0; i < 17; i++) begin
         s_tvalid = 1'b1; s_tdata = 32'hB0 + 32'(i);
         tick();
         if (i == 14) check("ff_ready_15", 64'(s_tready), 64'(1));
      end
      s_tvalid = 1'b0;
      check("ff_sready", 64'(s_tready), 64'(0));
      check("ff_led_full", 64'(led[3:2]), 64'(2'b10));
      check("ff_level", 64'(gpio1[15:8]), 64'(16));
      m_tready = 1'b1;

      // reset while word 7 of a generated packet is presented
      tb_seq = 16'h0030;
      push_gen(8);
      gpio0 = 32'd1;
      repeat (8) tick();
      reset = 1'b1;
      tick();
      check("abort_mvalid", 64'(m_tvalid), 64'(0));
      check("abort_led", 64'(led), 64'(12'h004));
      check("abort_gpio1", 64'(gpio1), 64'(0));
      check("abort_q_empty", 64'(exp_q.size()), 64'(0));
      tb_seq = '0;
      push_gen(PKT);
      reset = 1'b0;
      wait_done(1'b0);
      check("rs_q_empty", 64'(exp_q.size()), 64'(0));
      check("rs_cnt", 64'(gpio1[31:16]), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
